// File: rtl/pipe_mux_skid_if.sv
// Valid/ready bundle for pipe_mux_skid: upstream beat (data + select) and downstream result.
// master drives beats in and accepts results; slave is the selector itself.
interface pipe_mux_skid_if #(
  parameter int WIDTH = 32,
  parameter int N     = 5,
  parameter int SEL_W = 3
);
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/pipe_mux_skid.sv
// N-way WIDTH-bit registered selector with a 2-entry skid buffer (output reg + skid reg),
// out-of-range select flagging and a saturating error counter.
module pipe_mux_skid #(
  parameter int                 WIDTH       = 32,
  parameter int                 N           = 5,
  parameter int                 SEL_W       = 3,
  parameter logic [WIDTH-1:0]   DEFAULT_VAL = '0,
  parameter int                 ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_mux_skid_if.slave       bus,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]     out_data_q;
  logic                 out_err_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     skid_data_q;
  logic                 skid_err_q;
  logic                 in_ready_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic [WIDTH-1:0]     sel_data;
  logic                 sel_err;
  logic                 accept;
  logic                 emit;
  logic                 load_out_in;
  logic                 load_out_skid;
  logic                 load_skid;

  // Every select value resolves to a defined word; unmatched selects fall to the default.
  always_comb begin
    sel_data = DEFAULT_VAL;
    sel_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_data = bus.in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign accept = bus.in_valid & in_ready_q;
  assign emit   = out_valid_q & bus.out_ready;

  always_comb begin
    next_state    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state  = ONE;
          load_out_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && emit) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (emit) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so any upstream beat is simply not taken.
        if (emit) begin
          next_state    = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: begin
        next_state = EMPTY;
      end
    endcase
  end

  // Handshake flags are registered from next_state so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state       <= next_state;
      out_valid_q <= (next_state != EMPTY);
      in_ready_q  <= (next_state != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      if (load_out_in) begin
        out_data_q <= sel_data;
        out_err_q  <= sel_err;
      end else if (load_out_skid) begin
        out_data_q <= skid_data_q;
        out_err_q  <= skid_err_q;
      end
      if (load_skid) begin
        skid_data_q <= sel_data;
        skid_err_q  <= sel_err;
      end
    end
  end

  // Clear takes priority over a coincident out-of-range accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (clr_err) begin
      err_count_q <= '0;
    end else if (accept && sel_err && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_q <= err_count_q + ERR_CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_pipe_mux_skid.sv
// Directed and randomized checks of pipe_mux_skid against hand-computed values and a queue model.
module tb_pipe_mux_skid;
  localparam int WIDTH     = 32;
  localparam int N         = 5;
  localparam int SEL_W     = 3;
  localparam int ERR_CNT_W = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 clr_err;
  logic [ERR_CNT_W-1:0] err_count;

  int vectors;
  int miscompares;

  pipe_mux_skid_if #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) bus ();

  pipe_mux_skid #(
    .WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .DEFAULT_VAL(32'h0), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_err(clr_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_channels();
    for (int k = 0; k < N; k++) bus.in_data[k*WIDTH +: WIDTH] = 32'h1000_0000 + k;
  endtask

  task automatic drive(input logic valid, input logic [SEL_W-1:0] sel);
    bus.in_valid = valid;
    bus.in_sel   = sel;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    vectors++;
    if (bus.out_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %h expected 00000000", bus.out_data); end
    vectors++;
    if (bus.out_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_err: got %b expected 0", bus.out_err); end
    vectors++;
    if (err_count !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_err_count: got %0d expected 0", err_count); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd3);
    step();
    drive(1'b0, 3'd0);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1000_0003 || bus.out_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_beat: got v=%b d=%h e=%b expected v=1 d=10000003 e=0", bus.out_valid, bus.out_data, bus.out_err);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_drain: got v=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] exp;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, SEL_W'(i));
      step();
      exp = 32'h1000_0000 + i;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stream_%0d: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=1", i, bus.out_valid, bus.out_data, bus.in_ready, exp);
      end
    end
    drive(1'b0, 3'd0);
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_drain: got v=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd1);
    step();
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready_one: got %b expected 1", bus.in_ready); end
    drive(1'b1, 3'd2);
    step();
    drive(1'b0, 3'd0);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 32'h1000_0001) begin
      miscompares++;
      $display("[TB] FAIL bp_full: got rdy=%b d=%h expected rdy=0 d=10000001", bus.in_ready, bus.out_data);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1000_0001 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: got v=%b d=%h rdy=%b expected v=1 d=10000001 rdy=0", bus.out_valid, bus.out_data, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1000_0002 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_second: got v=%b d=%h rdy=%b expected v=1 d=10000002 rdy=1", bus.out_valid, bus.out_data, bus.in_ready);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain: got v=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_errors();
    logic [SEL_W-1:0] bad [3];
    bad[0] = 3'd6; bad[1] = 3'd7; bad[2] = 3'd5;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bad[i]);
      step();
      vectors++;
      if (bus.out_data !== 32'h0 || bus.out_err !== 1'b1 || err_count !== 8'(i + 1)) begin
        miscompares++;
        $display("[TB] FAIL err_sel_%0d: got d=%h e=%b cnt=%0d expected d=00000000 e=1 cnt=%0d", bad[i], bus.out_data, bus.out_err, err_count, i + 1);
      end
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd7);
      step();
    end
    vectors++;
    if (err_count !== 8'd255) begin miscompares++; $display("[TB] FAIL err_saturate: got %0d expected 255", err_count); end
    clr_err = 1'b1;
    drive(1'b1, 3'd6);
    step();
    clr_err = 1'b0;
    drive(1'b0, 3'd0);
    vectors++;
    if (err_count !== 8'd0 || bus.out_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_clear_wins: got cnt=%0d e=%b expected cnt=0 e=1", err_count, bus.out_err);
    end
    step();
    vectors++;
    if (err_count !== 8'd0) begin miscompares++; $display("[TB] FAIL err_clear_hold: got %0d expected 0", err_count); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0);
    step();
    drive(1'b1, 3'd1);
    step();
    drive(1'b0, 3'd0);
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_full: got rdy=%b expected 0", bus.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL areset_immediate: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_stale_%0d: got v=%b expected 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_random();
    beat_t                q[$];
    beat_t                nb;
    logic [ERR_CNT_W-1:0] exp_cnt;
    logic [SEL_W-1:0]     sel;
    logic                 acc;
    logic                 emt;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    exp_cnt = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      vectors++;
      if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() < 2)) begin
        miscompares++;
        $display("[TB] FAIL rand_flags_%0d: got v=%b rdy=%b expected v=%b rdy=%b", cyc, bus.out_valid, bus.in_ready, q.size() != 0, q.size() < 2);
      end
      if (q.size() != 0) begin
        vectors++;
        if (bus.out_data !== q[0].data || bus.out_err !== q[0].err) begin
          miscompares++;
          $display("[TB] FAIL rand_beat_%0d: got d=%h e=%b expected d=%h e=%b", cyc, bus.out_data, bus.out_err, q[0].data, q[0].err);
        end
      end
      vectors++;
      if (err_count !== exp_cnt || $isunknown({bus.out_data, bus.out_err})) begin
        miscompares++;
        $display("[TB] FAIL rand_cnt_%0d: got cnt=%0d d=%h expected cnt=%0d, no X", cyc, err_count, bus.out_data, exp_cnt);
      end
      for (int k = 0; k < N; k++) bus.in_data[k*WIDTH +: WIDTH] = $urandom;
      sel           = SEL_W'($urandom_range(0, 7));
      bus.in_sel    = sel;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      clr_err       = ($urandom_range(0, 49) == 0);
      acc = bus.in_valid && (q.size() < 2);
      emt = (q.size() != 0) && bus.out_ready;
      nb.data = (int'(sel) < N) ? bus.in_data[int'(sel)*WIDTH +: WIDTH] : 32'h0;
      nb.err  = (int'(sel) >= N);
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(nb);
      if (clr_err) exp_cnt = '0;
      else if (acc && nb.err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      step();
    end
    bus.in_valid = 1'b0;
    clr_err      = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    clr_err       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    load_channels();
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_errors();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
